// File: rtl/srt_div_pkg.sv
// Shared types and constants for the arbitrated SRT divider controller.
package srt_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DZ  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first valid index at or after ptr_i, wrapping.
module rr_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  localparam int unsigned KW = IDW + 1;

  logic [KW-1:0] w_k;
  logic          w_found;

  always_comb begin
    idx_o   = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_k = {1'b0, ptr_i} + KW'(i);
      if (w_k >= KW'(NREQ)) w_k = w_k - KW'(NREQ);
      if (!w_found && valid_i[w_k[IDW-1:0]]) begin
        w_found = 1'b1;
        idx_o   = w_k[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (w_found) grant_o[idx_o] = 1'b1;
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/srt_div_arb.sv
// Arbitrates NREQ requesters onto one external divider core, one division in flight.
module srt_div_arb
  import srt_div_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned TMO_CYC = 64,
  localparam int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_op1_i,
  input  logic [NREQ*WIDTH-1:0] req_op2_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]      rsp_quo_o,
  output logic [WIDTH-1:0]      rsp_rem_o,
  output logic [1:0]            rsp_err_o,
  output logic                  div_start_o,
  output logic [WIDTH-1:0]      div_op1_o,
  output logic [WIDTH-1:0]      div_op2_o,
  input  logic                  div_done_i,
  input  logic [WIDTH-1:0]      div_quo_i,
  input  logic [WIDTH-1:0]      div_rem_i
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  state_e           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CW-1:0]    r_cnt;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_quo;
  logic [WIDTH-1:0] r_rsp_rem;
  logic [1:0]       r_rsp_err;
  logic             r_div_start;
  logic [WIDTH-1:0] r_div_op1;
  logic [WIDTH-1:0] r_div_op2;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic             w_accept;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;

  rr_arb #(
    .NREQ(NREQ)
  ) u_rr_arb (
    .valid_i(req_valid_i),
    .ptr_i  (r_ptr),
    .grant_o(w_grant),
    .idx_o  (w_idx),
    .any_o  (w_any)
  );

  assign w_accept    = (r_state == StIdle) && w_any;
  assign req_ready_o = w_accept ? w_grant : '0;
  assign w_op1       = req_op1_i[w_idx*WIDTH +: WIDTH];
  assign w_op2       = req_op2_i[w_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_quo   <= '0;
      r_rsp_rem   <= '0;
      r_rsp_err   <= ERR_OK;
      r_div_start <= 1'b0;
      r_div_op1   <= '0;
      r_div_op2   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_id      <= w_idx;
            r_div_op1 <= w_op1;
            r_div_op2 <= w_op2;
            // Divide-by-zero never reaches the core.
            if (w_op2 == '0) begin
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= w_idx;
              r_rsp_quo   <= '1;
              r_rsp_rem   <= w_op1;
              r_rsp_err   <= ERR_DZ;
              r_state     <= StResp;
            end else begin
              r_div_start <= 1'b1;
              r_state     <= StIssue;
            end
          end
        end
        StIssue: begin
          r_div_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= StWait;
        end
        StWait: begin
          // Done has priority over a coincident watchdog expiry.
          if (div_done_i) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_quo   <= div_quo_i;
            r_rsp_rem   <= div_rem_i;
            r_rsp_err   <= ERR_OK;
            r_state     <= StResp;
          end else if (r_cnt == CW'(TMO_CYC - 1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_quo   <= '0;
            r_rsp_rem   <= '0;
            r_rsp_err   <= ERR_TMO;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_quo_o   = r_rsp_quo;
  assign rsp_rem_o   = r_rsp_rem;
  assign rsp_err_o   = r_rsp_err;
  assign div_start_o = r_div_start;
  assign div_op1_o   = r_div_op1;
  assign div_op2_o   = r_div_op2;

endmodule

// File: tb/tb_srt_div_arb.sv
// Directed and randomized bench for srt_div_arb with a behavioural divider stub and model.
module tb_srt_div_arb;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TMO_CYC = 64;
  localparam int unsigned IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*WIDTH-1:0] req_op1_i;
  logic [NREQ*WIDTH-1:0] req_op2_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [WIDTH-1:0]      rsp_quo_o;
  logic [WIDTH-1:0]      rsp_rem_o;
  logic [1:0]            rsp_err_o;
  logic                  div_start_o;
  logic [WIDTH-1:0]      div_op1_o;
  logic [WIDTH-1:0]      div_op2_o;
  logic                  div_done_i;
  logic [WIDTH-1:0]      div_quo_i;
  logic [WIDTH-1:0]      div_rem_i;

  always #5 clk = ~clk;

  srt_div_arb #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_op1_i  (req_op1_i),
    .req_op2_i  (req_op2_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_id_o   (rsp_id_o),
    .rsp_quo_o  (rsp_quo_o),
    .rsp_rem_o  (rsp_rem_o),
    .rsp_err_o  (rsp_err_o),
    .div_start_o(div_start_o),
    .div_op1_o  (div_op1_o),
    .div_op2_o  (div_op2_o),
    .div_done_i (div_done_i),
    .div_quo_i  (div_quo_i),
    .div_rem_i  (div_rem_i)
  );

  // Divider stub: done arrives stub_lat cycles after the start cycle unless hung.
  logic             stub_hang = 1'b0;
  int               stub_lat  = 1;
  logic             stray     = 1'b0;
  logic             s_done;
  logic [WIDTH-1:0] s_q, s_r;
  int               s_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_done <= 1'b0;
      s_cnt  <= 0;
      s_q    <= '0;
      s_r    <= '0;
    end else begin
      s_done <= 1'b0;
      if (div_start_o && !stub_hang) begin
        if (stub_lat <= 1) begin
          s_done <= 1'b1;
          s_q    <= div_op1_o / div_op2_o;
          s_r    <= div_op1_o % div_op2_o;
        end else begin
          s_cnt <= stub_lat - 1;
        end
      end else if (s_cnt > 0) begin
        s_cnt <= s_cnt - 1;
        if (s_cnt == 1) begin
          s_done <= 1'b1;
          s_q    <= div_op1_o / div_op2_o;
          s_r    <= div_op1_o % div_op2_o;
        end
      end
    end
  end

  assign div_done_i = s_done | stray;
  assign div_quo_i  = stray ? 8'hA5 : s_q;
  assign div_rem_i  = stray ? 8'h5A : s_r;

  logic [WIDTH-1:0] op1_a [NREQ];
  logic [WIDTH-1:0] op2_a [NREQ];
  logic [NREQ-1:0]  vld;
  int               n_cmp   = 0;
  int               n_err   = 0;
  int               exp_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req_op1_i[k*WIDTH +: WIDTH] = op1_a[k];
      req_op2_i[k*WIDTH +: WIDTH] = op2_a[k];
    end
    req_valid_i = vld;
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  // Called at a negedge where the DUT is idle with at least one valid requester.
  task automatic txn(input int hold, input bit keep, input bit stray_en, output int kk);
    int               k, n, starts, lat;
    bit               seen;
    logic [WIDTH-1:0] a, b, eq, er;
    logic [1:0]       ee;
    #1;
    k  = pick(vld, exp_ptr);
    kk = k;
    a  = op1_a[k];
    b  = op2_a[k];
    if (b == 0) begin
      eq = '1; er = a; ee = 2'b01; lat = 1;
    end else if (stub_hang) begin
      eq = '0; er = '0; ee = 2'b10; lat = 2 + TMO_CYC;
    end else begin
      eq = a / b; er = a % b; ee = 2'b00; lat = 2 + stub_lat;
    end
    rsp_ready_i = (hold == 0);
    chk("rsp_idle", rsp_valid_o, 0);
    chk("grant", req_ready_o, 32'(1) << k);
    n = 0; starts = 0; seen = 0;
    while (!seen && n < 2 * TMO_CYC + 20) begin
      @(negedge clk);
      n++;
      if (div_start_o) begin
        starts++;
        chk("start_op1", div_op1_o, a);
        chk("start_op2", div_op2_o, b);
        chk("start_time", n, 1);
      end
      if (rsp_valid_o) seen = 1;
      else chk("ready_busy", req_ready_o, 0);
      if (n == 1 && !keep) begin
        vld[k] = 1'b0;
        drive();
      end
    end
    chk("rsp_seen", seen, 1);
    chk("latency", n, lat);
    chk("starts", starts, (b != 0) ? 1 : 0);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid_o, 1);
      chk("rsp_id", rsp_id_o, k);
      chk("rsp_quo", rsp_quo_o, eq);
      chk("rsp_rem", rsp_rem_o, er);
      chk("rsp_err", rsp_err_o, ee);
      chk("ready_resp", req_ready_o, 0);
      if (h < hold) begin
        stray = stray_en && (h == 0);
        @(negedge clk);
        stray = 1'b0;
      end
    end
    rsp_ready_i = 1'b1;
    exp_ptr = (k + 1) % NREQ;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_id", rsp_id_o, 0);
    chk("rst_quo", rsp_quo_o, 0);
    chk("rst_rem", rsp_rem_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_start", div_start_o, 0);
    chk("rst_op1", div_op1_o, 0);
    chk("rst_op2", div_op2_o, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = '0;
      op2_a[i] = '0;
    end
    vld         = '0;
    rsp_ready_i = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rstn = 1'b1;
    @(negedge clk);

    // All four held valid: grants 0,1,2,3,0.
    op1_a[0] = 8'd100; op2_a[0] = 8'd9;
    op1_a[1] = WIDTH'($urandom_range(0, 255)); op2_a[1] = WIDTH'($urandom_range(1, 255));
    op1_a[2] = 8'd200; op2_a[2] = 8'd7;
    op1_a[3] = WIDTH'($urandom_range(0, 255)); op2_a[3] = WIDTH'($urandom_range(1, 255));
    vld = 4'hF;
    drive();
    for (int i = 0; i < 5; i++) begin
      stub_lat = $urandom_range(1, 8);
      txn(0, 1'b1, 1'b0, k);
      chk("rr_order", k, i % NREQ);
      @(negedge clk);
    end
    vld = '0;
    drive();
    @(negedge clk);

    // Single request 10/3 from requester 0.
    op1_a[0] = 8'd10; op2_a[0] = 8'd3; vld = 4'b0001; drive();
    stub_lat = 4;
    txn(0, 1'b0, 1'b0, k);
    @(negedge clk);

    // Divide-by-zero from requester 1.
    op1_a[1] = 8'd45; op2_a[1] = 8'd0; vld = 4'b0010; drive();
    txn(0, 1'b0, 1'b0, k);
    @(negedge clk);

    // Hung core, then a normal request.
    stub_hang = 1'b1;
    op1_a[3] = 8'd99; op2_a[3] = 8'd4; vld = 4'b1000; drive();
    txn(0, 1'b0, 1'b0, k);
    stub_hang = 1'b0;
    @(negedge clk);
    op1_a[0] = 8'd77; op2_a[0] = 8'd6; vld = 4'b0001; drive();
    stub_lat = 3;
    txn(0, 1'b0, 1'b0, k);
    @(negedge clk);

    // Back-pressure for 5 cycles with a stray done pulse.
    op1_a[1] = 8'd123; op2_a[1] = 8'd10; vld = 4'b0010; drive();
    stub_lat = 2;
    txn(5, 1'b0, 1'b1, k);
    @(negedge clk);

    // Asynchronous reset while waiting on a hung core.
    stub_hang = 1'b1;
    op1_a[2] = 8'd50; op2_a[2] = 8'd5; vld = 4'b0100; drive();
    #1;
    chk("pre_rst_grant", req_ready_o, 4'b0100);
    @(negedge clk);
    vld = '0; drive();
    repeat (4) @(negedge clk);
    #1 rstn = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rstn      = 1'b1;
    stub_hang = 1'b0;
    exp_ptr   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid_o, 0);
      chk("post_rst_start", div_start_o, 0);
    end
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = WIDTH'($urandom_range(0, 255));
      op2_a[i] = WIDTH'($urandom_range(1, 255));
    end
    vld = 4'hF; drive();
    stub_lat = 2;
    txn(0, 1'b0, 1'b0, k);
    chk("post_rst_grant", k, 0);
    @(negedge clk);

    // Random traffic.
    for (int it = 0; it < 16; it++) begin
      int hold;
      stub_lat = $urandom_range(1, 12);
      hold     = $urandom_range(0, 3);
      txn(hold, 1'b0, hold > 0 && $urandom_range(0, 1) == 1, k);
      op1_a[k] = WIDTH'($urandom_range(0, 255));
      op2_a[k] = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
      vld = vld | NREQ'($urandom_range(0, 15));
      if (vld == '0) vld = 4'b0001;
      drive();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
